addsub_serial: RTL and testbench



---
 rtl/addsub_serial.sv | 92 +++++++++
 tb/tb_addsub_serial.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first, with carry/borrow and signed overflow.
// Latency: N = WIDTH/DIGIT cycles from accepted start to a one-cycle done pulse.
// Backpressure: start is ignored while busy; a new start is accepted in IDLE or in the DONE cycle.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             sub_q;
    logic             carry;
    logic [KW-1:0]    k;

    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] bx_dig;
    logic [DIGIT:0]   sum;

    // b is stored already inverted for subtract; the initial carry supplies the +1.
    assign base   = 32'(k) * 32'(DIGIT);
    assign a_dig  = a_q[base +: DIGIT];
    assign bx_dig = bx_q[base +: DIGIT];
    assign sum    = {1'b0, a_dig} + {1'b0, bx_dig} + {{DIGIT{1'b0}}, carry};

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            bx_q   <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    result[base +: DIGIT] <= sum[DIGIT-1:0];
                    carry <= sum[DIGIT];
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= S_DONE;
                        k     <= '0;
                        c_out <= sum[DIGIT] ^ sub_q;
                        ovf   <= (a_dig[DIGIT-1] == bx_dig[DIGIT-1]) &&
                                 (sum[DIGIT-1] != a_dig[DIGIT-1]);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (start) begin
                        state <= S_RUN;
                        a_q   <= a;
                        bx_q  <= b ^ {WIDTH{sub}};
                        sub_q <= sub;
                        carry <= sub;
                        k     <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 16/4 main instance plus 8/8 and 8/1 parameter corners.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, c_out, ovf;
    logic [15:0] result;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, c_out8, ovf8;
    logic [7:0]  result8;

    logic        start1 = 1'b0, sub1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, c_out1, ovf1;
    logic [7:0]  result1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .c_out(c_out8), .ovf(ovf8)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(result1), .c_out(c_out1), .ovf(ovf1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one 16-bit op on the next edge (E0) and check the N=4 latency and outputs.
    task automatic op16(input string tag, input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic ec, input logic eo);
        start = 1'b1; sub = s; a = av; b = bv;
        tick();
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~s;
        chk({tag, "_busy_e0"}, busy, 1);
        tick(); tick(); tick();
        chk({tag, "_done_e3"}, done, 0);
        chk({tag, "_busy_e3"}, busy, 1);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_result"}, result, er);
        chk({tag, "_cout"}, c_out, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done8", done8, 0);
        chk("rst_done1", done1, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Back-to-back chain: each op's start is held during the previous op's DONE cycle.
        op16("sub_11_3",    1'b1, 16'd11,    16'd3,    16'h0008, 1'b0, 1'b0);
        op16("sub_1_2",     1'b1, 16'd1,     16'd2,    16'hFFFF, 1'b1, 1'b0);
        op16("sub_8000_1",  1'b1, 16'h8000,  16'd1,    16'h7FFF, 1'b0, 1'b1);
        op16("sub_5_5",     1'b1, 16'd5,     16'd5,    16'h0000, 1'b0, 1'b0);
        op16("add_ffff_1",  1'b0, 16'hFFFF,  16'h0001, 16'h0000, 1'b1, 1'b0);
        op16("add_7fff_1",  1'b0, 16'h7FFF,  16'h0001, 16'h8000, 1'b0, 1'b1);
        op16("add_14_0",    1'b0, 16'd14,    16'd0,    16'h000E, 1'b0, 1'b0);
        tick();
        chk("after_done_pulse", done, 0);
        chk("result_holds", result, 16'h000E);

        // Start pulsed at E2 while busy must be ignored.
        start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0101;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        tick();
        start = 1'b0;
        tick();
        chk("ign_busy_e3", busy, 1);
        tick();
        chk("ign_done", done, 1);
        chk("ign_result", result, 16'h1335);
        chk("ign_cout", c_out, 0);
        tick();
        chk("ign_no_relaunch_busy", busy, 0);
        chk("ign_no_relaunch_done", done, 0);

        // Reset asserted for edge E2 aborts, then a fresh start at E3 finishes after E7.
        start = 1'b1; sub = 1'b0; a = 16'h00F0; b = 16'h000F;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        op16("post_abort", 1'b1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);
        tick();

        // WIDTH=8, DIGIT=8: single processing cycle.
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'd3; b8 = 8'd1;
        tick();
        start8 = 1'b0;
        chk("w8d8_busy", busy8, 1);
        chk("w8d8_done_e0", done8, 0);
        tick();
        chk("w8d8_done", done8, 1);
        chk("w8d8_result", result8, 8'h02);
        chk("w8d8_cout", c_out8, 0);
        chk("w8d8_ovf", ovf8, 0);

        // WIDTH=8, DIGIT=1: eight processing cycles.
        start1 = 1'b1; sub1 = 1'b0; a1 = 8'h80; b1 = 8'h80;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("w8d1_done_e7", done1, 0);
        chk("w8d1_busy_e7", busy1, 1);
        tick();
        chk("w8d1_done", done1, 1);
        chk("w8d1_result", result1, 8'h00);
        chk("w8d1_cout", c_out1, 1);
        chk("w8d1_ovf", ovf1, 1);
        tick();
        chk("w8d1_idle", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
